uart_recv: RTL and testbench
============================

// Module: uart_recv
// PURPOSE
//   UART receive end of the 8N1 serial link: samples asynchronous uart_rxd,
//   reassembles LSB-first bytes and presents each with a one-cycle rx_done strobe.
//   Sits between the board RX pin and the byte consumer (loopback/command logic).
//   Line format and bit period are identical to the team's uart_send transmitter.
// PARAMETERS
//   BPS_CNT   16'd434   sys_clk cycles per bit (50 MHz / 115200); legal range 8..65535
// PORTS
//   sys_clk     in   1  system clock
//   sys_rst_n   in   1  reset: asynchronous, active-low
//   uart_rxd    in   1  serial input, asynchronous to sys_clk, idle high
//   rx_byte     out  8  last correctly received byte; held until the next good frame
//   rx_done     out  1  one-cycle pulse: rx_byte valid (updated in the same cycle)
//   rx_busy     out  1  high from start detection until return to IDLE
//   frame_err   out  1  one-cycle pulse: stop bit sampled low; byte discarded
//   parity_err  out  1  one-cycle pulse, UART_RECV_PARITY_EN only (else tied 0)
// BEHAVIOUR
//   Reset: rx_byte=8'h00, rx_done=0, rx_busy=0, frame_err=0, parity_err=0,
//     sync flops=1 (line idle), FSM=IDLE, clk_cnt=0, bit_cnt=0, shift reg=0.
//   Input: 2-FF synchronizer plus a 3rd delay flop; start edge = prev 1 and cur 0.
//   clk_cnt counts 0..BPS_CNT-1 per bit; the sample point is clk_cnt==BPS_CNT/2.
//   FSM:
//     IDLE  : on a start edge -> START, clk_cnt<=0, rx_busy<=1.
//     START : at the sample point, line 1 -> IDLE (glitch, no outputs);
//             line 0 -> DATA at the bit-period end (clk_cnt==BPS_CNT-1).
//     DATA  : sample bits 0..7 at each midpoint, shift in LSB first; after bit 7 -> STOP
//             (or -> PARITY when UART_RECV_PARITY_EN).
//     STOP  : at the midpoint, 1 -> rx_byte<=shift, rx_done=1; 0 -> frame_err=1.
//             Either way -> IDLE in the same cycle (half a bit early, for resync).
//   Latency: rx_done rises 9.5*BPS_CNT (+3 sync cycles) after the uart_rxd fall.
//   Line held low after a frame error: no new frame until the line returns high,
//     then a fresh high->low edge occurs (edge-triggered start only).
//   A start edge is ignored while not in IDLE; the shift reg is not cleared between frames.
//   rx_done/frame_err/parity_err are mutually exclusive and never assert for 2 cycles.
//   Async reset mid-frame aborts immediately; no strobe for the partial frame.
// CONFIGURATION
//   UART_RECV_PARITY_EN defined: frame is 8E1; PARITY state samples the bit after D7;
//     mismatch with ^data -> parity_err pulse at the stop sample, rx_done suppressed,
//     rx_byte held; a frame error takes priority (only frame_err pulses).
//     rx_done latency becomes 10.5*BPS_CNT.
//   Not defined: 8N1; no PARITY state; parity_err is a constant 0.
// STRUCTURE
//   uart_pkg: state encoding (IDLE/START/DATA/PARITY/STOP), BPS_CNT default constant,
//     data-bit count (8); shared with uart_send.
//   Sub-module uart_rx_sync: 2-FF synchronizer + delay flop; outputs rxd_s, start_edge.
//   The FSM, counters and shift register stay in uart_recv.
// TESTING (BPS_CNT=16 for sim; bench drives uart_rxd with a bit-accurate model)
//   Send 8'h55 8N1 -> one rx_done pulse, rx_byte=8'h55, frame_err=0, rx_busy falls.
//   Send 8'h00 then 8'hFF back-to-back (stop 1 bit) -> two rx_done pulses, 8'h00 then 8'hFF.
//   3-cycle low glitch on idle line -> no rx_done/frame_err; rx_busy pulses, FSM returns IDLE.
//   Send 8'hA3 with stop bit forced 0 -> frame_err pulse, no rx_done, rx_byte keeps old value.
//   Assert sys_rst_n low during bit 4 of 8'h3C, release, send 8'hC3 -> only rx_byte=8'hC3.
//   PARITY_EN: 8'h07 with parity 0 -> parity_err, no rx_done; with parity 1 -> rx_done, 8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period and data width.
// Used by both uart_recv and uart_send so line format stays identical.
package uart_pkg;

  localparam logic [15:0] BPS_CNT_DEF = 16'd434;
  localparam int          DATA_BITS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous RX pin into the sys_clk domain (2-FF synchronizer) and
// adds a delay flop so a clean high->low start edge can be detected.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic uart_rxd,
  output logic rxd_s,
  output logic start_edge
);

  logic sync_q1;
  logic sync_q2;
  logic sync_q3;

  // Flops reset to 1 so an idle line never looks like a start edge after reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      sync_q3 <= 1'b1;
    end else begin
      sync_q1 <= uart_rxd;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
    end
  end

  assign rxd_s      = sync_q2;
  assign start_edge = sync_q3 & ~sync_q2;

endmodule

// File: rtl/uart_recv.sv
// UART receiver: 8N1 by default, 8E1 when UART_RECV_PARITY_EN is defined.
// Samples each bit at mid-period and strobes rx_done / frame_err / parity_err.
module uart_recv
  import uart_pkg::*;
#(
  parameter logic [15:0] BPS_CNT = BPS_CNT_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [15:0] MID  = BPS_CNT >> 1;
  localparam logic [15:0] LAST = BPS_CNT - 16'd1;

  uart_state_t state;
  uart_state_t state_next;
  logic [15:0] clk_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        rxd_s;
  logic        start_edge;
  logic        at_mid;
  logic        at_end;
  logic        done_next;
  logic        ferr_next;
`ifdef UART_RECV_PARITY_EN
  logic        par_bit;
  logic        perr_next;
`endif

  uart_rx_sync u_sync (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .uart_rxd   (uart_rxd),
    .rxd_s      (rxd_s),
    .start_edge (start_edge)
  );

  assign at_mid = (clk_cnt == MID);
  assign at_end = (clk_cnt == LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  // STOP leaves at its midpoint so the next start edge is caught with margin.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RECV_PARITY_EN
    perr_next  = 1'b0;
`endif
    case (state)
      IDLE:   if (start_edge) state_next = START;
      START: begin
        if (at_mid && rxd_s) state_next = IDLE;
        else if (at_end)     state_next = DATA;
      end
      DATA: begin
        if (at_end && bit_cnt == 4'(DATA_BITS)) begin
`ifdef UART_RECV_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RECV_PARITY_EN
      PARITY: if (at_end) state_next = STOP;
`endif
      STOP: begin
        if (at_mid) begin
          state_next = IDLE;
          if (!rxd_s)         ferr_next = 1'b1;
`ifdef UART_RECV_PARITY_EN
          else if (par_bit != ^shift) perr_next = 1'b1;
`endif
          else                done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_byte   <= 8'h00;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      clk_cnt   <= 16'd0;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
    end else begin
      rx_done   <= done_next;
      frame_err <= ferr_next;
      rx_busy   <= (state_next != IDLE);
      if (done_next) rx_byte <= shift;
      if (state == IDLE || at_end) clk_cnt <= 16'd0;
      else                         clk_cnt <= clk_cnt + 16'd1;
      if (state == START) bit_cnt <= 4'd0;
      if (state == DATA && at_mid) begin
        shift   <= {rxd_s, shift[7:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

`ifdef UART_RECV_PARITY_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_next;
      if (state == PARITY && at_mid) par_bit <= rxd_s;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: bit-accurate line driver, expected-event
// queue filled by the stimulus, and an independent monitor that pops and compares.
module tb_uart_recv;

  localparam int BPS = 16;
`ifdef UART_RECV_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT = (PAR_EN ? 10 : 9) * BPS + BPS / 2 + 3;

  localparam int K_DONE = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  typedef struct {
    int       kind;
    bit [7:0] data;
    int       start_cyc;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       uart_rxd;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  exp_t     exp_q[$];
  bit [7:0] last_good;
  int       cyc;
  int       checks;
  int       errors;
  bit       prev_strobe;
  bit       busy_seen;

  uart_recv #(.BPS_CNT(16'(BPS))) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .uart_rxd   (uart_rxd),
    .rx_byte    (rx_byte),
    .rx_done    (rx_done),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic drive_bit(input bit b);
    uart_rxd = b;
    repeat (BPS) @(negedge sys_clk);
  endtask

  // Model: stop low is a frame error; else a wrong even-parity bit is a parity error.
  task automatic applyStimulus(input bit [7:0] data, input bit stop_bit, input bit par_bit, input int gap);
    exp_t e;
    e.data      = data;
    e.start_cyc = cyc;
    if (!stop_bit)                         e.kind = K_FERR;
    else if (PAR_EN && par_bit != ^data)   e.kind = K_PERR;
    else                                   e.kind = K_DONE;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (PAR_EN) drive_bit(par_bit);
    drive_bit(stop_bit);
    for (int i = 0; i < gap; i++) drive_bit(1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_rx_byte"}, int'(rx_byte), 0);
    checkOutput({tag, "_rx_done"}, int'(rx_done), 0);
    checkOutput({tag, "_rx_busy"}, int'(rx_busy), 0);
    checkOutput({tag, "_frame_err"}, int'(frame_err), 0);
    checkOutput({tag, "_parity_err"}, int'(parity_err), 0);
  endtask

  always @(negedge sys_clk) begin
    int   strobes;
    int   got_kind;
    int   lat;
    exp_t e;
    if (sys_rst_n) begin
      strobes = int'(rx_done) + int'(frame_err) + int'(parity_err);
      if (strobes != 0) begin
        checkOutput("strobe_exclusive", strobes, 1);
        checkOutput("strobe_width", int'(prev_strobe), 0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_strobe", strobes, 0);
        end else begin
          e = exp_q.pop_front();
          got_kind = rx_done ? K_DONE : (frame_err ? K_FERR : K_PERR);
          if (e.kind == K_DONE) last_good = e.data;
          lat = cyc - e.start_cyc;
          checkOutput("event_kind", got_kind, e.kind);
          checkOutput("rx_byte", int'(rx_byte), int'(last_good));
          checkOutput("latency_window", int'(lat >= LAT - 4 && lat <= LAT + 4), 1);
        end
      end
      prev_strobe = (strobes != 0);
      if (rx_busy) busy_seen = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit [7:0] d;
    bit       sb;
    bit       pb;
    int       gap;
    int       waited;
    checks    = 0;
    errors    = 0;
    last_good = 8'h00;
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    repeat (4) @(negedge sys_clk);
    check_reset_values("reset");
    sys_rst_n = 1'b1;
    repeat (BPS) @(negedge sys_clk);

    applyStimulus(8'h55, 1'b1, ^8'h55, 1);
    checkOutput("busy_low_after_55", int'(rx_busy), 0);

    applyStimulus(8'h00, 1'b1, 1'b0, 0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1);

    busy_seen = 1'b0;
    uart_rxd  = 1'b0;
    repeat (3) @(negedge sys_clk);
    uart_rxd  = 1'b1;
    repeat (2 * BPS) @(negedge sys_clk);
    checkOutput("glitch_busy_pulsed", int'(busy_seen), 1);
    checkOutput("glitch_busy_low", int'(rx_busy), 0);

    applyStimulus(8'hA3, 1'b0, ^8'hA3, 2);
    checkOutput("ferr_byte_held", int'(rx_byte), 'hFF);

    d = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    uart_rxd = d[4];
    repeat (BPS / 2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    last_good = 8'h00;
    repeat (2) @(negedge sys_clk);
    check_reset_values("midframe_reset");
    sys_rst_n = 1'b1;
    repeat (BPS) @(negedge sys_clk);
    applyStimulus(8'hC3, 1'b1, ^8'hC3, 1);

    applyStimulus(8'h07, 1'b1, 1'b0, 1);
    applyStimulus(8'h07, 1'b1, 1'b1, 1);

    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      sb  = ($urandom_range(0, 5) != 0);
      pb  = ($urandom_range(0, 4) == 0) ? ~(^d) : ^d;
      gap = sb ? $urandom_range(0, 3) : $urandom_range(1, 3);
      applyStimulus(d, sb, pb, gap);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(negedge sys_clk);
      waited++;
    end
    checkOutput("queue_drained", exp_q.size(), 0);
    repeat (BPS) @(negedge sys_clk);
    checkOutput("final_busy_low", int'(rx_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
